// File: rtl/src_select_sync.sv
// rtl/src_select_sync.sv - synchronised, debounced, glitch-free N-channel source selector (optional status: SRC_SELECT_STATUS_EN)
module src_select_sync #(
    parameter int NCH           = 4,
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 16,
    parameter int GAP_CYCLES    = 2,
    parameter int RESET_CH      = 0,
    localparam int SEL_W        = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]     dout,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 busy,
    output logic                 switch_pulse
`ifdef SRC_SELECT_STATUS_EN
    ,
    output logic [7:0]           switch_count,
    output logic                 abort_flag
`endif
);

    localparam int CNT_MAX = (STABLE_CYCLES > GAP_CYCLES) ? STABLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [SEL_W-1:0] RESET_SEL   = SEL_W'(RESET_CH);
    localparam logic [SEL_W:0]   NCH_V       = (SEL_W + 1)'(NCH);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {RUN, DEBOUNCE, GAP} state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] sync_q1, sel_s;
    logic [SEL_W-1:0] cand, cand_n, cur_sel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dout_n;
    logic [WIDTH-1:0] ch [NCH];
    logic             in_range, valid_req, commit;

    // Split the flat input bus into per-channel words.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch[k] = din[k*WIDTH +: WIDTH];
        end
    end

    assign in_range  = ({1'b0, sel_s} < NCH_V);
    assign valid_req = in_range && (sel_s != cur_sel);

    // Two-flop synchroniser for the switch input; parks on the reset channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= RESET_SEL;
            sel_s   <= RESET_SEL;
        end else begin
            sync_q1 <= sel;
            sel_s   <= sync_q1;
        end
    end

    // Next-state and output decode: debounce the candidate, blank during the gap, then commit.
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        cur_sel_n = cur_sel;
        commit    = 1'b0;
        dout_n    = ch[cur_sel];
        case (state)
            RUN: begin
                if (valid_req) begin
                    cand_n  = sel_s;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sel_s == cand) begin
                    if (cnt == STABLE_LAST) begin
                        cnt_n = '0;
                        if (GAP_CYCLES == 0) begin
                            commit  = 1'b1;
                            state_n = RUN;
                        end else begin
                            state_n = GAP;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if ((sel_s == cur_sel) || !in_range) begin
                    state_n = RUN;
                end else begin
                    cand_n = sel_s;
                    cnt_n  = '0;
                end
            end
            GAP: begin
                dout_n = '0;
                if (cnt == GAP_LAST) begin
                    commit  = 1'b1;
                    cnt_n   = '0;
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
        if (commit) begin
            cur_sel_n = cand;
        end
    end

    // Selector state and registered outputs; busy is taken from the next state so it rises on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cand         <= RESET_SEL;
            cnt          <= '0;
            cur_sel      <= RESET_SEL;
            dout         <= '0;
            busy         <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            cur_sel      <= cur_sel_n;
            dout         <= dout_n;
            busy         <= (state_n != RUN);
            switch_pulse <= commit;
        end
    end

`ifdef SRC_SELECT_STATUS_EN
    logic abort;
    assign abort = (state == DEBOUNCE) && (sel_s != cand) && ((sel_s == cur_sel) || !in_range);

    // Saturating commit counter and sticky abort indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_count <= 8'd0;
            abort_flag   <= 1'b0;
        end else begin
            if (commit && (switch_count != 8'hFF)) begin
                switch_count <= switch_count + 8'd1;
            end
            if (abort) begin
                abort_flag <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_src_select_sync.sv
// tb/tb_src_select_sync.sv - scoreboard bench for src_select_sync with a time-based reference model
module tb_src_select_sync;

    localparam int NCH      = 4;
    localparam int WIDTH    = 8;
    localparam int STABLE   = 4;
    localparam int GAP      = 2;
    localparam int RESET_CH = 0;
    localparam logic [31:0] DIN_FIXED = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [7:0]  dout;
    logic [1:0]  cur_sel;
    logic        busy;
    logic        switch_pulse;
`ifdef SRC_SELECT_STATUS_EN
    logic [7:0]  switch_count;
    logic        abort_flag;
`endif

    always #5 clk = ~clk;

    src_select_sync #(
        .NCH(NCH), .WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .GAP_CYCLES(GAP), .RESET_CH(RESET_CH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .din(din),
        .dout(dout),
        .cur_sel(cur_sel),
        .busy(busy),
        .switch_pulse(switch_pulse)
`ifdef SRC_SELECT_STATUS_EN
        ,
        .switch_count(switch_count),
        .abort_flag(abort_flag)
`endif
    );

    typedef struct packed {
        logic [7:0] dout;
        logic [1:0] cur;
        logic       busy;
        logic       pulse;
        logic [7:0] cnt;
        logic       abrt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a request accepted at edge t must see the candidate on edges t+1..t+STABLE,
    // dout is blanked on edges t+STABLE+1..t+STABLE+GAP and the commit lands on edge t+STABLE+GAP.
    int m_cur, m_cand, m_req, m_edge, m_s1, m_s2, m_count;
    bit m_abort;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur   = RESET_CH;
        m_cand  = RESET_CH;
        m_req   = -1;
        m_edge  = 0;
        m_s1    = RESET_CH;
        m_s2    = RESET_CH;
        m_count = 0;
        m_abort = 0;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.dout  = 8'h00;
        e.cur   = 2'(RESET_CH);
        e.busy  = 1'b0;
        e.pulse = 1'b0;
        e.cnt   = 8'h00;
        e.abrt  = 1'b0;
        return e;
    endfunction

    task automatic model_step(output exp_t e);
        int ss, k;
        bit commit;
        ss     = m_s2;
        commit = 0;
        m_edge++;
        e.dout = din[m_cur*8 +: 8];
        if (m_req >= 0 && (m_edge - m_req) > STABLE) e.dout = 8'h00;
        if (m_req < 0) begin
            if (ss < NCH && ss != m_cur) begin
                m_req  = m_edge;
                m_cand = ss;
            end
        end else begin
            k = m_edge - m_req;
            if (k <= STABLE) begin
                if (ss == m_cand) begin
                    if (k == STABLE && GAP == 0) commit = 1;
                end else if (ss == m_cur || ss >= NCH) begin
                    m_req   = -1;
                    m_abort = 1;
                end else begin
                    m_cand = ss;
                    m_req  = m_edge;
                end
            end else if (k == STABLE + GAP) begin
                commit = 1;
            end
        end
        if (commit) begin
            m_cur = m_cand;
            m_req = -1;
            if (m_count < 255) m_count++;
        end
        e.cur   = 2'(m_cur);
        e.busy  = (m_req >= 0);
        e.pulse = commit;
        e.cnt   = 8'(m_count);
        e.abrt  = m_abort;
        m_s2 = m_s1;
        m_s1 = int'(sel);
    endtask

    task automatic step_cycle();
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            e = reset_exp();
        end else begin
            model_step(e);
        end
        q.push_back(e);
        #1;
    endtask

    task automatic hold(input int n, input bit rand_din);
        for (int i = 0; i < n; i++) begin
            step_cycle();
            if (rand_din) din = $urandom();
        end
    endtask

    task automatic gap_reset();
        bool_found: begin
            bit found;
            exp_t e;
            found = 0;
            sel = 2'((m_cur + 2) % NCH);
            for (int i = 0; i < 30 && !found; i++) begin
                step_cycle();
                if (m_req >= 0 && (m_edge - m_req) >= STABLE) found = 1;
            end
            chk("reach_gap", int'(found), 1);
            rst_n = 1'b0;
            #1;
            chk("rst_dout", int'(dout), 0);
            chk("rst_cur_sel", int'(cur_sel), RESET_CH);
            chk("rst_pulse", int'(switch_pulse), 0);
            if (q.size() > 0) void'(q.pop_back());
            e = reset_exp();
            q.push_back(e);
            model_reset();
            sel = 2'(RESET_CH);
            hold(2, 0);
            rst_n = 1'b1;
            hold(6, 0);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dout", int'(dout), int'(e.dout));
                chk("cur_sel", int'(cur_sel), int'(e.cur));
                chk("busy", int'(busy), int'(e.busy));
                chk("switch_pulse", int'(switch_pulse), int'(e.pulse));
`ifdef SRC_SELECT_STATUS_EN
                chk("switch_count", int'(switch_count), int'(e.cnt));
                chk("abort_flag", int'(abort_flag), int'(e.abrt));
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        sel   = 2'(RESET_CH);
        din   = DIN_FIXED;
        model_reset();
        hold(2, 0);
        rst_n = 1'b1;
        hold(5, 0);

        sel = 2'd2;
        hold(14, 0);

        sel = 2'd1;
        hold(2, 0);
        sel = 2'd2;
        hold(12, 0);

        sel = 2'd1;
        hold(4, 0);
        sel = 2'd3;
        hold(15, 0);

        gap_reset();

        for (int s = 0; s < 40; s++) begin
            sel = 2'($urandom_range(0, NCH - 1));
            hold($urandom_range(1, 12), 1);
        end
        din = DIN_FIXED;

        gap_reset();

        for (int i = 0; i < 300; i++) begin
            sel = (i % 2) ? 2'd1 : 2'd2;
            hold(12, (i % 7) == 0);
        end
`ifdef SRC_SELECT_STATUS_EN
        chk("switch_count_sat", int'(switch_count), 255);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
